// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
//   Player controller. It sits between the keyboard decoder and the player
//   sprite drawer. Horizontal motion uses fixed-point acceleration and
//   deceleration and is clamped to the field bounds. A lives, respawn and
//   invulnerability state machine reacts to ball collisions.
//
// Ports
//   clk           in   1   system clock
//   resetN        in   1   synchronous active-low reset
//   startOfFrame  in   1   one-cycle frame tick
//   rightArrow    in   1   right key held
//   leftArrow     in   1   left key held
//   collision     in   1   player/ball overlap (level)
//   topLeftX      out  11  player X, pixels
//   topLeftY      out  11  player Y, pixels (constant INITIAL_Y)
//   playerVisible out  1   sprite draw enable (blinks while invulnerable)
//   livesLeft     out  3   remaining lives
//   hitPulse      out  1   one-cycle strobe on an accepted hit
//   gameOver      out  1   sticky until reset
// -----------------------------------------------------------------------------
module player_motion_ctrl #(
    parameter int INITIAL_X      = 280,
    parameter int INITIAL_Y      = 420,
    parameter int PLAYER_WIDTH   = 26,
    parameter int X_MIN          = 5,
    parameter int X_MAX          = 635,
    parameter int FRAC_BITS      = 6,
    parameter int MAX_SPEED      = 192,
    parameter int ACCEL          = 32,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 30,
    parameter int INVULN_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        rightArrow,
    input  logic        leftArrow,
    input  logic        collision,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        playerVisible,
    output logic [2:0]  livesLeft,
    output logic        hitPulse,
    output logic        gameOver
);

    typedef enum logic [1:0] {ALIVE, HIT, INVULN, GAME_OVER} stateT;

    // Fixed-point constants. The scale is 2^FRAC_BITS.
    localparam logic signed [19:0] POS_INIT  = 20'(INITIAL_X << FRAC_BITS);
    localparam logic signed [19:0] POS_MIN   = 20'(X_MIN << FRAC_BITS);
    localparam logic signed [19:0] POS_MAX   = 20'((X_MAX - PLAYER_WIDTH) << FRAC_BITS);
    localparam logic signed [19:0] SPD_MAX   = 20'(MAX_SPEED);
    localparam logic signed [19:0] SPD_ACCEL = 20'(ACCEL);
    localparam logic [7:0]         RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0]         INVULN_LAST  = 8'(INVULN_FRAMES - 1);

    stateT              state, nextState;
    logic signed [19:0] pos, posNext;
    logic signed [19:0] speed, speedNext;
    logic [7:0]         frameCnt, cntNext;
    logic [2:0]         livesNext;
    logic               hitNext;
    logic               moveEn;

    // Candidate motion result for this frame, used only when moveEn is set.
    logic signed [19:0] accSpeed, sumPos, movedPos, movedSpeed;

    always_comb begin
        accSpeed = speed;
        unique case ({rightArrow, leftArrow})
            2'b10: begin
                accSpeed = speed + SPD_ACCEL;
                if (accSpeed > SPD_MAX) accSpeed = SPD_MAX;
            end
            2'b01: begin
                accSpeed = speed - SPD_ACCEL;
                if (accSpeed < -SPD_MAX) accSpeed = -SPD_MAX;
            end
            default: begin
                // Coast toward zero. The speed stops at zero and does not cross it.
                if (speed > SPD_ACCEL)       accSpeed = speed - SPD_ACCEL;
                else if (speed < -SPD_ACCEL) accSpeed = speed + SPD_ACCEL;
                else                         accSpeed = '0;
            end
        endcase

        // The position advances by the speed computed on this same tick.
        sumPos     = pos + accSpeed;
        movedPos   = sumPos;
        movedSpeed = accSpeed;
        // Stopping at a wall kills the momentum.
        if (sumPos < POS_MIN) begin
            movedPos   = POS_MIN;
            movedSpeed = '0;
        end else if (sumPos > POS_MAX) begin
            movedPos   = POS_MAX;
            movedSpeed = '0;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        nextState     = state;
        posNext       = pos;
        speedNext     = speed;
        cntNext       = frameCnt;
        livesNext     = livesLeft;
        hitNext       = 1'b0;
        moveEn        = 1'b0;
        playerVisible = 1'b1;
        gameOver      = 1'b0;

        unique case (state)
            ALIVE: begin
                // A collision wins over a coincident frame tick. No motion happens that tick.
                if (collision) begin
                    nextState = HIT;
                    livesNext = livesLeft - 3'd1;
                    hitNext   = 1'b1;
                    cntNext   = '0;
                end else begin
                    moveEn = startOfFrame;
                end
            end
            HIT: begin
                playerVisible = 1'b0;
                if (startOfFrame) begin
                    if (frameCnt == RESPAWN_LAST) begin
                        if (livesLeft == 3'd0) begin
                            nextState = GAME_OVER;
                        end else begin
                            nextState = INVULN;
                            posNext   = POS_INIT;
                            speedNext = '0;
                            cntNext   = '0;
                        end
                    end else begin
                        cntNext = frameCnt + 8'd1;
                    end
                end
            end
            INVULN: begin
                playerVisible = ~frameCnt[2];
                moveEn        = startOfFrame;
                if (startOfFrame) begin
                    if (frameCnt == INVULN_LAST) begin
                        nextState = ALIVE;
                        cntNext   = '0;
                    end else begin
                        cntNext = frameCnt + 8'd1;
                    end
                end
            end
            default: begin
                playerVisible = 1'b0;
                gameOver      = 1'b1;
            end
        endcase

        if (moveEn) begin
            posNext   = movedPos;
            speedNext = movedSpeed;
        end
    end

    // NOTE: the registers use non-blocking assignments. All of them then update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= ALIVE;
            pos       <= POS_INIT;
            speed     <= '0;
            frameCnt  <= '0;
            livesLeft <= 3'(LIVES);
            hitPulse  <= 1'b0;
        end else begin
            state     <= nextState;
            pos       <= posNext;
            speed     <= speedNext;
            frameCnt  <= cntNext;
            livesLeft <= livesNext;
            hitPulse  <= hitNext;
        end
    end

    // Truncating shift. The clamped position is never negative.
    assign topLeftX = 11'(pos >>> FRAC_BITS);
    assign topLeftY = 11'(INITIAL_Y);

endmodule
